// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester, memory and error signals of the two-master memory arbiter
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ifu_reqValid;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_respValid;
  logic [DATA_W-1:0]     ifu_rdata;

  logic                  lsu_reqValid;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [1:0]            lsu_size;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_respValid;
  logic [DATA_W-1:0]     lsu_rdata;

  logic                  mem_reqValid;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [1:0]            mem_size;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_respValid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  err;

  // arbiter side
  modport slave (
    input  ifu_reqValid, ifu_addr,
    input  lsu_reqValid, lsu_addr, lsu_wen, lsu_size, lsu_wdata, lsu_wmask,
    input  mem_respValid, mem_rdata,
    output ifu_respValid, ifu_rdata,
    output lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_wen, mem_size, mem_wdata, mem_wmask,
    output err
  );

  // core plus memory side
  modport master (
    output ifu_reqValid, ifu_addr,
    output lsu_reqValid, lsu_addr, lsu_wen, lsu_size, lsu_wdata, lsu_wmask,
    output mem_respValid, mem_rdata,
    input  ifu_respValid, ifu_rdata,
    input  lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_wen, mem_size, mem_wdata, mem_wmask,
    input  err
  );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - round-robin IFU/LSU arbiter onto one memory port with a response watchdog
module mem_arb #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic     clock,
  input logic     reset,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2
  } state_t;

  // A zero timeout turns the watchdog off entirely.
  localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  state_t           state_nx;
  logic             last_lsu;   // 1 = LSU had the most recent grant
  logic [CNT_W-1:0] cnt;
  logic             grant_ifu;
  logic             grant_lsu;
  logic             timeout;
  logic             done;

  // State register; reset drops mem_reqValid at once because it decodes from state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Grant selection, completion detection and response routing.
  always_comb begin
    state_nx          = state;
    grant_ifu         = 1'b0;
    grant_lsu         = 1'b0;
    timeout           = 1'b0;
    done              = 1'b0;
    bus.mem_reqValid  = 1'b0;
    bus.ifu_respValid = 1'b0;
    bus.ifu_rdata     = '0;
    bus.lsu_respValid = 1'b0;
    bus.lsu_rdata     = '0;
    bus.err           = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the master that did not win last time goes first.
        if (bus.ifu_reqValid && (!bus.lsu_reqValid || last_lsu)) begin
          grant_ifu = 1'b1;
          state_nx  = BUSY_IFU;
        end else if (bus.lsu_reqValid) begin
          grant_lsu = 1'b1;
          state_nx  = BUSY_LSU;
        end
      end
      BUSY_IFU, BUSY_LSU: begin
        bus.mem_reqValid = 1'b1;
        // A real response on the last watchdog cycle wins over the abort.
        timeout = WD_EN && (cnt == CNT_LAST) && !bus.mem_respValid;
        done    = bus.mem_respValid || timeout;
        bus.err = timeout;
        if (done) begin
          state_nx = IDLE;
        end
        if (state == BUSY_IFU) begin
          bus.ifu_respValid = done;
          bus.ifu_rdata     = bus.mem_respValid ? bus.mem_rdata : '0;
        end else begin
          bus.lsu_respValid = done;
          bus.lsu_rdata     = bus.mem_respValid ? bus.mem_rdata : '0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Capture the winning request, track fairness and run the watchdog counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_wen   <= 1'b0;
      bus.mem_size  <= 2'b00;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
      last_lsu      <= 1'b1;
      cnt           <= '0;
    end else if (grant_ifu) begin
      bus.mem_addr  <= bus.ifu_addr;
      bus.mem_wen   <= 1'b0;
      bus.mem_size  <= 2'b10;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
      last_lsu      <= 1'b0;
      cnt           <= '0;
    end else if (grant_lsu) begin
      bus.mem_addr  <= bus.lsu_addr;
      bus.mem_wen   <= bus.lsu_wen;
      bus.mem_size  <= bus.lsu_size;
      bus.mem_wdata <= bus.lsu_wdata;
      bus.mem_wmask <= bus.lsu_wmask;
      last_lsu      <= 1'b1;
      cnt           <= '0;
    end else if (state != IDLE) begin
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-master, one-slave memory arbiter. Lets the instruction-fetch channel and the load/store channel of the cpu core share a single memory port.
- Sits between the core's `io_ifu_*` / `io_lsu_*` ports and the memory/bus adapter.
- Serialises requests with round-robin fairness, registers the winning request onto the memory port and routes the response back.
- A per-transaction watchdog returns an error response if memory never answers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT_CYCLES, 255, busy cycles before abort; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifu_reqValid  in  1  fetch request; held high until ifu_respValid.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_respValid  out  1  one-cycle fetch completion pulse.
- ifu_rdata  out  DATA_W  fetch data, valid with ifu_respValid.
- lsu_reqValid  in  1  load/store request; held high until lsu_respValid.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wen  in  1  1 = store.
- lsu_size  in  2  access size code, passed through.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  byte-lane write mask.
- lsu_respValid  out  1  one-cycle load/store completion pulse.
- lsu_rdata  out  DATA_W  load data, valid with lsu_respValid.
- mem_reqValid  out  1  request to memory; high for the whole transaction.
- mem_addr  out  ADDR_W  registered address.
- mem_wen  out  1  registered write enable.
- mem_size  out  2  registered size.
- mem_wdata  out  DATA_W  registered store data.
- mem_wmask  out  DATA_W/8  registered write mask.
- mem_respValid  in  1  one-cycle completion from memory.
- mem_rdata  in  DATA_W  read data, valid with mem_respValid.
- err  out  1  pulses with a respValid caused by timeout.

Behaviour:

Reset:
- State goes to IDLE and last_grant to LSU, so IFU wins the first tie.
- All mem_* registers are 0, counter is 0, and all outputs are 0 (combinational outputs via IDLE).
- Reset asserted mid-transaction drops mem_reqValid immediately. Any later mem_respValid is ignored.

FSM states: IDLE, BUSY_IFU, BUSY_LSU.

IDLE:
- Only ifu_reqValid high: capture ifu_addr, wen=0, wmask=0, size=2'b10, wdata=0 into mem_* regs; go to BUSY_IFU.
- Only lsu_reqValid high: capture all lsu_* fields; go to BUSY_LSU.
- Both high: grant the master not in last_grant. last_grant updates on each grant.
- Neither high: stay in IDLE.

BUSY_x:
- mem_reqValid = 1. mem_* regs stay stable, and requester inputs are ignored.
- The counter increments each cycle.
- On mem_respValid, in the same cycle combinationally: x_respValid = 1 and x_rdata = mem_rdata. Then return to IDLE and clear the counter.
- On counter == TIMEOUT_CYCLES-1 with no mem_respValid (watchdog enabled): x_respValid = 1, err = 1, x_rdata = 0. Then go to IDLE and clear the counter.
- mem_respValid and timeout in the same cycle: the response wins and err = 0.

Latency and outputs:
- Request visible on mem_* exactly 1 cycle after the grant cycle.
- Minimum latency is 2 cycles from reqValid to respValid. One idle cycle always separates transactions.
- The non-granted master's respValid and rdata are 0.
- x_rdata is 0 whenever x_respValid = 0.

Requester and memory rules:
- A requester must drop reqValid the cycle after respValid unless it is issuing a new request. A held reqValid is treated as a new request.
- mem_respValid in IDLE is spurious and ignored: no respValid, no state change.
- Only one outstanding transaction; no pipelining.

Test Plan:
- IFU-only fetch: ifu_reqValid=1, ifu_addr=0x80000000; memory answers 3 cycles after mem_reqValid with 0x00100073.
  -> mem_addr=0x80000000, mem_wen=0 from cycle 1; ifu_respValid pulses once with ifu_rdata=0x00100073; err=0; lsu_respValid stays 0.
- LSU store: lsu_addr=0x80001002, wen=1, wmask=4'b1100, wdata=0xABCD0000.
  -> identical values on mem_*, held stable until mem_respValid; lsu_respValid pulses once.
- Simultaneous requests after reset, both held for two transactions.
  -> IFU is granted first, then LSU; a third simultaneous request goes to IFU (alternation).
- Timeout with TIMEOUT_CYCLES=4 and memory silent.
  -> after 4 busy cycles: lsu_respValid=1, err=1, lsu_rdata=0; FSM returns to IDLE; a late mem_respValid is ignored.
- Response on the timeout cycle: mem_respValid with 0x1234 on busy cycle 4 (TIMEOUT_CYCLES=4).
  -> respValid=1, rdata=0x1234, err=0.
- Reset mid-transaction: assert reset in BUSY_LSU.
  -> mem_reqValid is 0 before the next clock edge; after release the FSM is in IDLE and a fresh IFU request completes normally.
